// File: rtl/module_display_pkg.sv
// rtl/module_display_pkg.sv - shared states, segment constants and helpers for the multiplexed display
package module_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba patterns; A-F only guard against impossible codes.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // ceil(bin_w * log10(2)) in fixed point; log10(2) is never a rational multiple.
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/module_bin2bcd_seq.sv
// rtl/module_bin2bcd_seq.sv - sequential double-dabble converter, one binary bit per clock
module module_bin2bcd_seq
  import module_display_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int BCD_D = bcd_digits(BIN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_D-1:0]   bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [4*BCD_D-1:0] bcd_q, bcd_d;
  logic [4*BCD_D-1:0] adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = bcd_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        for (int i = 0; i < BCD_D; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/module_display_multiplex.sv
// rtl/module_display_multiplex.sv - binary-to-BCD display driver scanning N common-anode digits
// DISPLAY_LZB_EN enables leading-zero blanking.
module module_display_multiplex
  import module_display_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int N_DIGITS    = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic [6:0]          catodo,
  output logic [N_DIGITS-1:0] anodo
);

  localparam int BCD_D  = bcd_digits(BIN_W);
  localparam int PAD_D  = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  conv_done;
  logic [4*BCD_D-1:0]    bcd;
  logic [4*PAD_D-1:0]    bcd_pad;

  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic                  ovf_q, ovf_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [6:0]            catodo_q, catodo_d;
  logic [N_DIGITS-1:0]   anodo_q, anodo_d;
  logic [3:0]            sel_digit;
`ifdef DISPLAY_LZB_EN
  logic [N_DIGITS-1:0]   blank_mask;
  logic                  nz_above;
  logic                  sel_blank;
`endif

  module_bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_D (BCD_D)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst),
    .start (load),
    .bin   (bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*BCD_D-1:0] = bcd;
  end

  always_comb begin
    digits_d = digits_q;
    ovf_d    = ovf_q;
    if (conv_done) begin
      digits_d = bcd_pad[4*N_DIGITS-1:0];
      ovf_d    = |(bcd_pad >> (4*N_DIGITS));
    end

    pre_d  = pre_q + PRE_W'(1);
    scan_d = scan_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d  = '0;
      scan_d = (scan_q == SCAN_W'(N_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
    end

    // Outputs follow scan_q one cycle late and use the post-commit digits, so the
    // first dwell after reset is full length and a new value lands with no ghosting.
    anodo_d   = ~(N_DIGITS'(1) << scan_q);
    sel_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) sel_digit = digits_d[4*i +: 4];
    end

`ifdef DISPLAY_LZB_EN
    blank_mask = '0;
    nz_above   = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      nz_above      = nz_above | (digits_d[4*i +: 4] != 4'd0);
      blank_mask[i] = ~nz_above;
    end
    sel_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) sel_blank = blank_mask[i];
    end
    if (ovf_d)          catodo_d = SEG_DASH;
    else if (sel_blank) catodo_d = SEG_BLANK;
    else                catodo_d = seg_decode(sel_digit);
`else
    if (ovf_d) catodo_d = SEG_DASH;
    else       catodo_d = seg_decode(sel_digit);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      pre_q    <= '0;
      scan_q   <= '0;
      catodo_q <= SEG_BLANK;
      anodo_q  <= '1;
    end else begin
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      pre_q    <= pre_d;
      scan_q   <= scan_d;
      catodo_q <= catodo_d;
      anodo_q  <= anodo_d;
    end
  end

  assign catodo = catodo_q;
  assign anodo  = anodo_q;

endmodule

// File: doc/module_display_multiplex.md
Name: module_display_multiplex

Overview:
- Parametrised successor to the fixed 3-digit display path.
- Accepts a binary value of BIN_W bits with a load strobe and converts it to BCD sequentially (shift-add-3 / double dabble, one bit per clock).
- Drives an N_DIGITS multiplexed common-anode 7-segment display by time-scanning the anodes.
- Sits after the operand/result selector; the FSM strobes load whenever the shown value must change.

Parameters:
- BIN_W, 8, width of the binary input.
- N_DIGITS, 3, number of display digits and anode lines.
- REFRESH_DIV, 50000, clock cycles each digit stays lit. Must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; bin is sampled in the same cycle.
- bin  in  BIN_W  unsigned value to display.
- busy  out  1  high while a conversion is in progress.
- catodo  out  7  segment lines gfedcba (catodo[0]=a), active-low.
- anodo  out  N_DIGITS  digit enables, active-low; anodo[0]=units digit.

Behaviour:
- Reset (rst=0, asynchronous):
  - catodo=7'h7F, anodo=all 1s, busy=0.
  - Displayed value := 0; scan index := 0; prescaler := 0.
  - Any conversion in progress is aborted.
- FSM states:
  - IDLE → CONV on load=1; bin is captured and the BCD accumulator is cleared.
  - CONV runs BIN_W cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left one bit, bringing in the binary MSB.
  - CONV → COMMIT after the BIN_W-th shift.
  - COMMIT copies the BCD digits into the display register in one cycle (atomic update), then → IDLE.
- busy=1 in CONV and COMMIT (BIN_W+1 cycles, starting the cycle after load).
- New value is visible on catodo from the cycle after COMMIT; latency is BIN_W+2 cycles from load.
- load while busy=1 is ignored. No queueing; the conversion in progress is unaffected.
- Internal BCD width: ceil(BIN_W·log10(2)) digits, so no intermediate loss.
- Overflow: if any BCD digit above index N_DIGITS-1 is nonzero, every digit shows a dash (segment g only, catodo=7'b0111111).
- Scanning:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count, the scan index increments, wrapping from N_DIGITS-1 to 0.
  - Exactly one anodo bit is 0 at any time after reset.
  - catodo is the registered decode of the selected digit, updated in the same cycle as anodo (no ghosting).
- Display continues scanning the old value during CONV.
- A load in the same cycle as the scan index changes is handled independently by both paths.
- Digit decode: 0–9 use the standard pattern (0 → 7'b1000000, 1 → 7'b1111001, …). Non-BCD codes cannot occur.

Optional Feature:
- Macro: DISPLAY_LZB_EN.
- Defined: leading-zero blanking. Digits above the most significant nonzero digit show catodo=7'h7F while their anode still scans. Digit 0 is never blanked. Overflow dashes override blanking.
- Undefined: all digits show their decoded value, including leading zeros.

Decomposition:
- Package module_display_pkg:
  - state enum {IDLE, CONV, COMMIT}.
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
  - 16-entry digit-to-segment function.
  - Function computing BCD digit count from BIN_W.
- Sub-module module_bin2bcd_seq: sequential double dabble with start/busy/done and a bcd output. The top level holds the display register, overflow detect, prescaler, scan counter and decode.

Test Plan (BIN_W=8, N_DIGITS=3, REFRESH_DIV=4 unless stated):
- Hold rst=0 for 3 cycles → catodo=7'h7F, anodo=3'b111, busy=0. Release → anodo=3'b110, catodo=7'b1000000, each anode held 4 cycles.
- load with bin=255 → busy high for 9 cycles; value appears 10 cycles after load. Scan shows digit0=7'b0010010 (5), digit1=5, digit2=7'b0100100 (2).
- load bin=100, then load bin=42 three cycles later → second load ignored; display shows 1,0,0. After busy falls, load bin=42 → 0,4,2.
- Scan wrap: observe 16 cycles → anodo sequence 110,101,011,110, each held exactly 4 cycles.
- BIN_W=10, bin=1000 → all three digits show 7'b0111111. bin=999 → 9,9,9.
- bin=7 with DISPLAY_LZB_EN → digits 2,1 show 7'h7F and digit0 shows 7; without the macro → 0,0,7. bin=0 with macro → digit0 shows 0.
- rst asserted 4 cycles into a conversion → outputs return to reset values immediately. After release, the display shows 0 and busy=0.
